apmu_ibex_dyn_branch_predict: RTL

//  Parametrised dynamic successor to the static fetch-stage branch predictor. Decodes JAL/BRANCH/
//  C.J/C.JAL/C.BEQZ/C.BNEZ and computes the target (PC + sign-extended imm) as before. Conditional

---
 rtl/apmu_ibex_dyn_branch_predict.sv | 150 +++++++++++++++
 1 files changed

// File: rtl/apmu_ibex_dyn_branch_predict.sv
// Dynamic fetch-stage branch predictor.
// It decodes JAL, BRANCH, C.J, C.JAL, C.BEQZ and C.BNEZ and forms the target as PC + sign-extended imm.
// Conditional branches are predicted from a tagged table of saturating counters.
// The execute stage trains that table; on a table miss the predictor falls back to static backward-taken.
module apmu_ibex_dyn_branch_predict #(
  parameter int unsigned BhtEntries = 64,
  parameter int unsigned TagWidth   = 6,
  parameter int unsigned CtrWidth   = 2
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic [31:0] fetch_rdata_i,
  input  logic [31:0] fetch_pc_i,
  input  logic        fetch_valid_i,
  output logic        predict_branch_taken_o,
  output logic [31:0] predict_branch_pc_o,
  input  logic        update_valid_i,
  input  logic [31:0] update_pc_i,
  input  logic        update_taken_i,
  input  logic        flush_i
);

  localparam int unsigned IdxW = $clog2(BhtEntries);
  // TagWidth=0 keeps a 1-bit tag tied to zero on both sides, so the compare is always true.
  localparam int unsigned TagW = (TagWidth > 0) ? TagWidth : 1;
  localparam logic [CtrWidth-1:0] CtrMax   = '1;
  localparam logic [CtrWidth-1:0] CtrWeakT = CtrWidth'(1) << (CtrWidth - 1);
  localparam logic [CtrWidth-1:0] CtrWeakN = CtrWeakT - CtrWidth'(1);

  // ---------------- decode ----------------
  logic        instr_j, instr_b, instr_cj, instr_cb;
  logic [31:0] imm_j, imm_b, imm_cj, imm_cb, imm_sel;
  logic        is_compressed;

  assign is_compressed = (fetch_rdata_i[1:0] == 2'b01);
  assign instr_j  = (fetch_rdata_i[6:0] == 7'h6F);
  assign instr_b  = (fetch_rdata_i[6:0] == 7'h63);
  assign instr_cj = is_compressed &
                    ((fetch_rdata_i[15:13] == 3'b101) | (fetch_rdata_i[15:13] == 3'b001));
  assign instr_cb = is_compressed &
                    ((fetch_rdata_i[15:13] == 3'b110) | (fetch_rdata_i[15:13] == 3'b111));

  assign imm_j  = {{12{fetch_rdata_i[31]}}, fetch_rdata_i[19:12], fetch_rdata_i[20],
                   fetch_rdata_i[30:21], 1'b0};
  assign imm_b  = {{20{fetch_rdata_i[31]}}, fetch_rdata_i[7], fetch_rdata_i[30:25],
                   fetch_rdata_i[11:8], 1'b0};
  assign imm_cj = {{20{fetch_rdata_i[12]}}, fetch_rdata_i[12], fetch_rdata_i[8],
                   fetch_rdata_i[10:9], fetch_rdata_i[6], fetch_rdata_i[7], fetch_rdata_i[2],
                   fetch_rdata_i[11], fetch_rdata_i[5:3], 1'b0};
  assign imm_cb = {{23{fetch_rdata_i[12]}}, fetch_rdata_i[12], fetch_rdata_i[6:5],
                   fetch_rdata_i[2], fetch_rdata_i[11:10], fetch_rdata_i[4:3], 1'b0};

  // Pick the immediate matching the decoded type; non-branches fall back to the B-type field.
  always_comb begin
    imm_sel = imm_b;
    if (instr_j) begin
      imm_sel = imm_j;
    end else if (instr_cj) begin
      imm_sel = imm_cj;
    end else if (instr_cb) begin
      imm_sel = imm_cb;
    end
  end

  // ---------------- table index / tag ----------------
  logic [IdxW-1:0] lk_idx, upd_idx;
  logic [TagW-1:0] lk_tag, upd_tag;

  assign lk_idx  = fetch_pc_i[IdxW:1];
  assign upd_idx = update_pc_i[IdxW:1];

  if (TagWidth > 0) begin : g_tag
    assign lk_tag  = fetch_pc_i[IdxW+TagWidth:IdxW+1];
    assign upd_tag = update_pc_i[IdxW+TagWidth:IdxW+1];
  end else begin : g_no_tag
    assign lk_tag  = '0;
    assign upd_tag = '0;
  end

  logic [BhtEntries-1:0] valid_reg;
  logic [TagW-1:0]       tag_reg [BhtEntries];
  logic [CtrWidth-1:0]   ctr_reg [BhtEntries];

  // ---------------- lookup ----------------
  logic lk_hit, branch_pred;

  assign lk_hit      = valid_reg[lk_idx] & (tag_reg[lk_idx] == lk_tag);
  assign branch_pred = lk_hit ? ctr_reg[lk_idx][CtrWidth-1] : imm_sel[31];

  assign predict_branch_taken_o = fetch_valid_i &
                                  (instr_j | instr_cj | ((instr_b | instr_cb) & branch_pred));
  assign predict_branch_pc_o    = fetch_pc_i + imm_sel;

  // ---------------- update ----------------
  logic                upd_hit;
  logic [CtrWidth-1:0] ctr_cur, ctr_next;
  logic [BhtEntries-1:0] entry_we;

  assign upd_hit = valid_reg[upd_idx] & (tag_reg[upd_idx] == upd_tag);
  assign ctr_cur = ctr_reg[upd_idx];

  // Train a hit entry with a saturating step, or allocate a miss as weakly taken/not-taken.
  always_comb begin
    ctr_next = ctr_cur;
    if (!upd_hit) begin
      ctr_next = update_taken_i ? CtrWeakT : CtrWeakN;
    end else if (update_taken_i) begin
      if (ctr_cur != CtrMax) ctr_next = ctr_cur + CtrWidth'(1);
    end else begin
      if (ctr_cur != '0) ctr_next = ctr_cur - CtrWidth'(1);
    end
  end

  // A flush in the same cycle suppresses the update.
  for (genvar gi = 0; gi < BhtEntries; gi++) begin : g_we
    assign entry_we[gi] = update_valid_i & ~flush_i & (upd_idx == IdxW'(gi));
  end

  // Table state: async clear on reset; flush drops only the valid bits.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      valid_reg <= '0;
      for (int i = 0; i < BhtEntries; i++) begin
        tag_reg[i] <= '0;
        ctr_reg[i] <= '0;
      end
    end else begin
      if (flush_i) valid_reg <= '0;
      for (int i = 0; i < BhtEntries; i++) begin
        if (entry_we[i]) begin
          valid_reg[i] <= 1'b1;
          tag_reg[i]   <= upd_tag;
          ctr_reg[i]   <= ctr_next;
        end
      end
    end
  end

  // Only part of each instruction/PC word feeds the logic.
  logic unused_bits;
  assign unused_bits = ^{fetch_rdata_i, update_pc_i};

`ifndef SYNTHESIS
  a_decode_onehot0 : assert property (@(posedge clk_i) disable iff (!rst_ni)
    fetch_valid_i |-> $onehot0({instr_j, instr_b, instr_cj, instr_cb}));
  a_update_pc_known : assert property (@(posedge clk_i) disable iff (!rst_ni)
    update_valid_i |-> !$isunknown(update_pc_i));
`endif

endmodule
